// File: rtl/inst_queue.sv
// In-order instruction queue between fetch and issue; circular buffer with explicit count.
// Define IQ_BYPASS_EN for a zero-latency fetch->issue path when the queue is empty.
module inst_queue #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              flush,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [DATA_W-1:0] push_inst,
  input  logic [DATA_W-1:0] push_pc,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [DATA_W-1:0] pop_inst,
  output logic [DATA_W-1:0] pop_pc,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] CountFull = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_inst_q [DEPTH];
  logic [DATA_W-1:0] mem_pc_q   [DEPTH];

  logic [ADDR_W-1:0] head_q, head_d;
  logic [ADDR_W-1:0] tail_q, tail_d;
  logic [ADDR_W:0]   count_q, count_d;

  logic stored_valid;
  logic bypass;
  logic bypass_take;
  logic push_fire;
  logic stored_pop;
  logic wr_en;

  always_comb begin
    push_ready   = (count_q != CountFull);
    stored_valid = (count_q != '0) & ~flush;
`ifdef IQ_BYPASS_EN
    bypass       = (count_q == '0) & push_valid & ~flush;
`else
    bypass       = 1'b0;
`endif
    pop_valid    = stored_valid | bypass;
    push_fire    = push_valid & push_ready & ~flush;
    bypass_take  = bypass & pop_ready;
    // A bypassed entry consumed this cycle never lands in storage.
    wr_en        = push_fire & ~bypass_take;
    stored_pop   = stored_valid & pop_ready;

    pop_inst = '0;
    pop_pc   = '0;
    if (bypass) begin
      pop_inst = push_inst;
      pop_pc   = push_pc;
    end else if (stored_valid) begin
      pop_inst = mem_inst_q[head_q];
      pop_pc   = mem_pc_q[head_q];
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr_en) begin
        tail_d = tail_q + 1'b1;
      end
      if (stored_pop) begin
        head_d = head_q + 1'b1;
      end
      unique case ({wr_en, stored_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_inst_q[tail_q] <= push_inst;
      mem_pc_q[tail_q]   <= push_pc;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_inst_queue.sv
// Randomized and directed bench for inst_queue against a queue-based reference model.
module tb_inst_queue;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              nRST;
  logic              flush;
  logic              push_valid;
  logic              push_ready;
  logic [DATA_W-1:0] push_inst;
  logic [DATA_W-1:0] push_pc;
  logic              pop_valid;
  logic              pop_ready;
  logic [DATA_W-1:0] pop_inst;
  logic [DATA_W-1:0] pop_pc;
  logic [ADDR_W:0]   count;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] mq[$];
  logic        e_pv, e_pr, byp;
  logic [31:0] e_inst, e_pc;
  int          e_cnt;

  inst_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .nRST      (nRST),
    .flush     (flush),
    .push_valid(push_valid),
    .push_ready(push_ready),
    .push_inst (push_inst),
    .push_pc   (push_pc),
    .pop_valid (pop_valid),
    .pop_ready (pop_ready),
    .pop_inst  (pop_inst),
    .pop_pc    (pop_pc),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Drive one cycle's inputs and derive the expected outputs from the model.
  task automatic apply(input logic pv, input logic pr, input logic fl,
                       input logic [31:0] pc, input logic [31:0] inst);
    push_valid = pv;
    pop_ready  = pr;
    flush      = fl;
    push_pc    = pc;
    push_inst  = inst;
    #3;
    e_cnt = mq.size();
    e_pr  = (mq.size() != DEPTH);
`ifdef IQ_BYPASS_EN
    byp = (mq.size() == 0) && pv && !fl;
`else
    byp = 1'b0;
`endif
    e_pv   = !fl && (mq.size() != 0 || byp);
    e_inst = '0;
    e_pc   = '0;
    if (e_pv) begin
      if (byp) {e_pc, e_inst} = {pc, inst};
      else     {e_pc, e_inst} = mq[0];
    end
  endtask

  task automatic advance();
    if (flush) begin
      mq.delete();
    end else if (!(byp && pop_ready)) begin
      if (e_pv && pop_ready) mq.delete(0);
      if (push_valid && e_pr) mq.push_back({push_pc, push_inst});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0; flush = 0; push_valid = 0; pop_ready = 0; push_pc = '0; push_inst = '0;
    #12;
    n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_vec++; if (pop_valid !== 1'b0) begin n_err++; $display("FAIL reset_pop_valid: got %b want 0", pop_valid); end
    n_vec++; if (push_ready !== 1'b1) begin n_err++; $display("FAIL reset_push_ready: got %b want 1", push_ready); end
    n_vec++; if (pop_inst !== 32'h0 || pop_pc !== 32'h0) begin
      n_err++; $display("FAIL reset_data: got %h/%h want 0/0", pop_inst, pop_pc); end
    @(posedge clk); #1;
    nRST = 1'b1;
    mq.delete();
    // Asynchronous reset while entries are queued.
    for (int i = 0; i < 3; i++) begin apply(1, 0, 0, 32'h300 + 4 * i, $urandom); advance(); end
    #2 nRST = 1'b0;
    #1;
    mq.delete();
    n_vec++; if (count !== 4'd0 || pop_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_midop: got count=%0d pv=%b want 0/0", count, pop_valid); end
    @(posedge clk); #1;
    nRST = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      apply(1, 0, 0, 32'(4 * i), $urandom);
      n_vec++; if (count !== 4'(e_cnt)) begin n_err++; $display("FAIL fill_count: got %0d want %0d", count, e_cnt); end
      advance();
    end
    apply(1, 0, 0, 32'h20, $urandom);
    n_vec++; if (count !== 4'd8) begin n_err++; $display("FAIL fill_full_count: got %0d want 8", count); end
    n_vec++; if (push_ready !== 1'b0) begin n_err++; $display("FAIL fill_push_ready: got %b want 0", push_ready); end
    advance();
    for (int i = 0; i < 8; i++) begin
      apply(0, 1, 0, '0, '0);
      n_vec++; if (pop_valid !== 1'b1 || pop_pc !== 32'(4 * i)) begin
        n_err++; $display("FAIL fill_pop_order: got pv=%b pc=%h want 1/%h", pop_valid, pop_pc, 4 * i); end
      n_vec++; if (pop_inst !== e_inst) begin n_err++; $display("FAIL fill_pop_inst: got %h want %h", pop_inst, e_inst); end
      advance();
    end
    apply(0, 0, 0, '0, '0);
    n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL fill_drained: got %0d want 0", count); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 6; i++) begin apply(1, 0, 0, 32'h100 + 4 * i, $urandom); advance(); end
    for (int i = 0; i < 6; i++) begin apply(0, 1, 0, '0, '0); advance(); end
    for (int i = 0; i < 5; i++) begin apply(1, 0, 0, 32'h180 + 4 * i, $urandom); advance(); end
    for (int i = 0; i < 5; i++) begin
      apply(0, 1, 0, '0, '0);
      n_vec++; if (pop_pc !== 32'h180 + 4 * i || pop_inst !== e_inst) begin
        n_err++; $display("FAIL wrap_pop: got pc=%h inst=%h want %h/%h", pop_pc, pop_inst, 32'h180 + 4 * i, e_inst); end
      advance();
    end
    apply(0, 0, 0, '0, '0);
    n_vec++; if (count !== 4'd0 || pop_valid !== 1'b0) begin
      n_err++; $display("FAIL wrap_empty: got count=%0d pv=%b want 0/0", count, pop_valid); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 3; i++) begin apply(1, 0, 0, 32'h200 + 4 * i, $urandom); advance(); end
    apply(1, 1, 0, 32'h20C, $urandom);
    n_vec++; if (pop_pc !== 32'h200 || count !== 4'd3) begin
      n_err++; $display("FAIL simul_head: got pc=%h count=%0d want 200/3", pop_pc, count); end
    advance();
    for (int i = 1; i < 4; i++) begin
      apply(0, 1, 0, '0, '0);
      if (i == 1) begin
        n_vec++; if (count !== 4'd3) begin n_err++; $display("FAIL simul_count: got %0d want 3", count); end
      end
      n_vec++; if (pop_pc !== 32'h200 + 4 * i) begin
        n_err++; $display("FAIL simul_order: got %h want %h", pop_pc, 32'h200 + 4 * i); end
      advance();
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin apply(1, 0, 0, 32'h400 + 4 * i, $urandom); advance(); end
    apply(1, 1, 1, 32'h500, $urandom);
    n_vec++; if (pop_valid !== 1'b0 || pop_inst !== 32'h0) begin
      n_err++; $display("FAIL flush_cycle: got pv=%b inst=%h want 0/0", pop_valid, pop_inst); end
    advance();
    apply(0, 0, 0, '0, '0);
    n_vec++; if (count !== 4'd0 || pop_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_after: got count=%0d pv=%b want 0/0", count, pop_valid); end
  endtask

  task automatic test_bypass();
    apply(1, 1, 0, 32'h40, 32'h2001000A);
`ifdef IQ_BYPASS_EN
    n_vec++; if (pop_valid !== 1'b1 || pop_inst !== 32'h2001000A || pop_pc !== 32'h40) begin
      n_err++; $display("FAIL bypass_same: got pv=%b inst=%h pc=%h want 1/2001000a/40", pop_valid, pop_inst, pop_pc); end
    advance();
    apply(0, 0, 0, '0, '0);
    n_vec++; if (count !== 4'd0 || pop_valid !== 1'b0) begin
      n_err++; $display("FAIL bypass_after: got count=%0d pv=%b want 0/0", count, pop_valid); end
`else
    n_vec++; if (pop_valid !== 1'b0) begin n_err++; $display("FAIL bypass_none: got pv=%b want 0", pop_valid); end
    advance();
    apply(0, 1, 0, '0, '0);
    n_vec++; if (count !== 4'd1 || pop_valid !== 1'b1 || pop_pc !== 32'h40 || pop_inst !== 32'h2001000A) begin
      n_err++; $display("FAIL bypass_next: got count=%0d pv=%b pc=%h inst=%h want 1/1/40/2001000a",
                        count, pop_valid, pop_pc, pop_inst); end
    advance();
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      int phase;
      phase = (i / 50) % 3;
      apply(($urandom_range(0, 3) < (phase == 0 ? 3 : 1)),
            ($urandom_range(0, 3) < (phase == 1 ? 3 : 2)),
            ($urandom_range(0, 31) == 0), $urandom, $urandom);
      n_vec++; if (count !== 4'(e_cnt) || push_ready !== e_pr || pop_valid !== e_pv ||
                   pop_inst !== e_inst || pop_pc !== e_pc) begin
        n_err++;
        $display("FAIL random[%0d]: got cnt=%0d pr=%b pv=%b inst=%h pc=%h want %0d/%b/%b/%h/%h",
                 i, count, push_ready, pop_valid, pop_inst, pop_pc, e_cnt, e_pr, e_pv, e_inst, e_pc);
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    advance();
    test_wrap();
    advance();
    test_simultaneous();
    test_flush();
    advance();
    test_bypass();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
